// File: rtl/mac_rr_scheduler.sv
// rtl/mac_rr_scheduler.sv - round-robin shared signed MAC dot-product scheduler
module mac_rr_scheduler #(
    parameter int NREQ = 2,
    parameter int DW   = 16,
    parameter int AW   = 32,
    parameter int LENW = 8,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    input  logic [NREQ-1:0]      in_valid,
    input  logic [NREQ*DW-1:0]   in_a,
    input  logic [NREQ*DW-1:0]   in_b,
    output logic [NREQ-1:0]      in_ready,
    output logic                 res_valid,
    output logic [AW-1:0]        res_data,
    output logic [IDW-1:0]       res_id,
    input  logic                 res_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUT} state_t;

    state_t                 state, state_nx;
    logic [IDW-1:0]         gid, rr_ptr, grant_id;
    logic                   grant_found;
    logic [LENW-1:0]        len_q, count, grant_len;
    logic                   s1_v;
    logic signed [DW-1:0]   s1_a, s1_b;
    logic signed [AW-1:0]   acc;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;
    logic                   fire, last_pair;
    int                     idx;

    // First requesting index at or above the rr pointer, wrapping at NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign grant_len = len[grant_id*LENW +: LENW];
    assign fire      = (state == STREAM) && in_valid[gid];
    assign last_pair = fire && (count == len_q - LENW'(1));
    assign prod      = s1_a * s1_b;
    assign prod_ext  = AW'(prod);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = '0;
        case (state)
            IDLE: begin
                if (grant_found)
                    state_nx = (grant_len == '0) ? OUT : STREAM;
            end
            STREAM: begin
                in_ready[gid] = 1'b1;
                if (last_pair) state_nx = DRAIN;
            end
            DRAIN: state_nx = OUT;
            OUT: begin
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gid    <= '0;
            rr_ptr <= '0;
            len_q  <= '0;
            count  <= '0;
            acc    <= '0;
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
        end else begin
            s1_v <= fire;
            if (fire) begin
                s1_a  <= in_a[gid*DW +: DW];
                s1_b  <= in_b[gid*DW +: DW];
                count <= count + LENW'(1);
            end
            // Stage 1 is never valid in IDLE, so clearing here cannot drop a product.
            if (state == IDLE && grant_found) begin
                gid   <= grant_id;
                len_q <= grant_len;
                count <= '0;
                acc   <= '0;
            end else if (s1_v) begin
                acc <= acc + prod_ext;
            end
            if (state == OUT && res_ready)
                rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
        end
    end

    assign res_valid = (state == OUT);
    assign res_data  = res_valid ? acc : '0;
    assign res_id    = res_valid ? gid : '0;
    assign busy      = (state != IDLE);

endmodule
